custom_buff_use_sequencer: RTL and testbench
============================================

CUSTOM_BUFF_USE_SEQUENCER -- requirements
Module: custom_buff_use_sequencer

Interface
REQ-001 SHALL have parameter NUM_BUFF, default 4, number of buffer-use enables.
REQ-002 SHALL have parameter SCHED_DEPTH, default 32, number of schedule steps; CNT_W = clog2(SCHED_DEPTH), derived, not overridable.
REQ-003 clk  in  1  single clock, rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 cfg_we  in  1  schedule-table write strobe.
REQ-006 cfg_addr  in  CNT_W  table write index.
REQ-007 cfg_wdata  in  NUM_BUFF  enable pattern to store.
REQ-008 cfg_len  in  CNT_W  index of last step; sampled at start.
REQ-009 cfg_loop  in  1  1 = wrap to step 0 after last step; sampled at start.
REQ-010 start  in  1  begin sequence, single-cycle pulse.
REQ-011 stall  in  1  hold current step.
REQ-012 abort  in  1  terminate sequence.
REQ-013 busy  out  1  high in RUN.
REQ-014 done  out  1  one-cycle pulse on normal completion.
REQ-015 cnt  out  CNT_W  current step index.
REQ-016 buff_use  out  NUM_BUFF  registered buffer-use enables.
REQ-017 buff_use_valid  out  1  buff_use carries a step pattern.
REQ-018 cfg_err  out  1  one-cycle pulse when a write is rejected.

Function
REQ-019 Table SHALL be SCHED_DEPTH x NUM_BUFF registers. Writes SHALL be accepted only in IDLE or DONE, with cfg_addr < SCHED_DEPTH. A write in RUN, or with an out-of-range address, SHALL be dropped and SHALL pulse cfg_err the next cycle.
REQ-020 FSM states: IDLE, RUN, DONE.
REQ-021 IDLE->RUN on start. Effects: cnt <= 0; latch cfg_loop; latch len = min(cfg_len, SCHED_DEPTH-1).
REQ-022 In RUN, each cycle with stall=0 is an advancing cycle:
  - buff_use <= table[cnt], buff_use_valid <= 1.
  - If cnt != len: cnt <= cnt+1.
REQ-023 Latency: the pattern of step k SHALL appear on buff_use exactly one cycle after the advancing cycle in which cnt = k.
REQ-024 Last step (advancing with cnt == len):
  - Looping: cnt <= 0, stay in RUN, no done.
  - Not looping: go to DONE, pulse done in the DONE cycle.
REQ-025 In RUN with stall=1: cnt holds, buff_use <= 0, buff_use_valid <= 0. No step SHALL be skipped or repeated across a stall.
REQ-026 DONE->IDLE unconditionally after one cycle. In DONE: buff_use_valid = 0, buff_use = 0 after the final pattern has been presented.
REQ-027 abort in RUN: next state IDLE, cnt <= 0, buff_use <= 0, buff_use_valid <= 0, no done. abort SHALL take priority over stall and last-step handling.
REQ-028 start SHALL be ignored in RUN and in DONE.
REQ-029 start with a same-cycle cfg_we in IDLE: the write SHALL commit, and step reads SHALL use the new value.
REQ-030 len = 0 SHALL produce a single-step sequence; with looping, step 0 repeats every advancing cycle.
REQ-031 busy SHALL equal (state == RUN).

Reset
REQ-032 rst SHALL asynchronously force:
  - state IDLE;
  - cnt, buff_use, buff_use_valid, busy, done, cfg_err to 0;
  - latched len/loop to 0;
  - all table entries to 0.
REQ-033 rst asserted mid-RUN SHALL end the sequence without a done pulse. First start after deassertion SHALL behave per REQ-021.

Structure
REQ-034 Package custom_buff_pkg SHALL hold the FSM state typedef (IDLE/RUN/DONE), default NUM_BUFF/SCHED_DEPTH constants, and the CNT_W derivation function.
REQ-035 Table SHALL be sub-module custom_sched_regfile: write port plus one asynchronous read port, parametrised on NUM_BUFF and SCHED_DEPTH.
REQ-036 FSM, counter and output registers SHALL live in the top module.

Verification
REQ-037 One-shot run:
  - Load entries 5=1000, 6=1100, 7=0110, 8=0010; cfg_len=8, cfg_loop=0; pulse start.
  - buff_use sequence 0000 x5, 1000, 1100, 0110, 0010.
  - done pulses once; busy low afterwards.
REQ-038 Loop run:
  - cfg_len=2, cfg_loop=1, entries 0..2 = 0001, 0010, 0100.
  - Repeating 0001, 0010, 0100 with no gap at the wrap; no done.
  - abort returns IDLE with outputs 0.
REQ-039 Stall:
  - Assert stall 3 cycles while cnt=3.
  - buff_use=0 and valid=0 for those 3 cycles, then resumes with table[3].
  - Total valid count = len+1.
REQ-040 Rejected write:
  - cfg_we during RUN: cfg_err pulses, entry unchanged on the next run.
  - Non-power-of-2 build (SCHED_DEPTH=26), write to address 27: cfg_err pulses.
REQ-041 Reset mid-run: assert rst asynchronously at cnt=10. All outputs 0 immediately; table reads 0; no done.
REQ-042 Parametrised build NUM_BUFF=8, SCHED_DEPTH=64: cfg_len=63 one-shot yields 64 valid steps, then done.

Source files
------------

// File: rtl/custom_buff_pkg.sv
// Shared types and constants for the buffer-use sequencer: FSM states,
// default sizes and the counter-width derivation.
package custom_buff_pkg;

    localparam int NUM_BUFF_DEF    = 4;
    localparam int SCHED_DEPTH_DEF = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // A one-entry table still needs a one-bit index.
    function automatic int cnt_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/custom_sched_regfile.sv
// Schedule table: SCHED_DEPTH x NUM_BUFF registers with one write port
// and one asynchronous read port; cleared by reset.
module custom_sched_regfile
    import custom_buff_pkg::*;
#(
    parameter int NUM_BUFF    = NUM_BUFF_DEF,
    parameter int SCHED_DEPTH = SCHED_DEPTH_DEF,
    localparam int CNT_W      = cnt_width(SCHED_DEPTH)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                we,
    input  logic [CNT_W-1:0]    waddr,
    input  logic [NUM_BUFF-1:0] wdata,
    input  logic [CNT_W-1:0]    raddr,
    output logic [NUM_BUFF-1:0] rdata
);

    localparam logic [CNT_W:0] DEPTH_V = (CNT_W+1)'(SCHED_DEPTH);

    logic [NUM_BUFF-1:0] mem [SCHED_DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SCHED_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we && ({1'b0, waddr} < DEPTH_V)) begin
            mem[waddr] <= wdata;
        end
    end

    // Indices past the last entry (non power-of-2 depths) read as zero.
    assign rdata = ({1'b0, raddr} < DEPTH_V) ? mem[raddr] : '0;

endmodule

// File: rtl/custom_buff_use_sequencer.sv
// Steps through a programmable table of buffer-use patterns, one pattern
// per non-stalled cycle, optionally looping; supports abort and stall.
module custom_buff_use_sequencer
    import custom_buff_pkg::*;
#(
    parameter int NUM_BUFF    = NUM_BUFF_DEF,
    parameter int SCHED_DEPTH = SCHED_DEPTH_DEF,
    localparam int CNT_W      = cnt_width(SCHED_DEPTH)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_we,
    input  logic [CNT_W-1:0]    cfg_addr,
    input  logic [NUM_BUFF-1:0] cfg_wdata,
    input  logic [CNT_W-1:0]    cfg_len,
    input  logic                cfg_loop,
    input  logic                start,
    input  logic                stall,
    input  logic                abort,
    output logic                busy,
    output logic                done,
    output logic [CNT_W-1:0]    cnt,
    output logic [NUM_BUFF-1:0] buff_use,
    output logic                buff_use_valid,
    output logic                cfg_err,
    output state_e              dbg_state
);

    localparam logic [CNT_W:0]   DEPTH_V = (CNT_W+1)'(SCHED_DEPTH);
    localparam logic [CNT_W-1:0] LAST    = CNT_W'(SCHED_DEPTH - 1);

    state_e              state, state_nx;
    logic [CNT_W-1:0]    cnt_nx, len_q, len_nx, len_clamped;
    logic                loop_q, loop_nx;
    logic [NUM_BUFF-1:0] buff_use_nx, step_pattern;
    logic                valid_nx, err_nx, wr_ok, addr_ok;

    // Writes are only safe while the table is not being stepped through.
    assign addr_ok     = ({1'b0, cfg_addr} < DEPTH_V);
    assign wr_ok       = cfg_we && (state != RUN) && addr_ok;
    assign err_nx      = cfg_we && !wr_ok;
    assign len_clamped = (cfg_len > LAST) ? LAST : cfg_len;

    custom_sched_regfile #(
        .NUM_BUFF    (NUM_BUFF),
        .SCHED_DEPTH (SCHED_DEPTH)
    ) u_regfile (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_ok),
        .waddr (cfg_addr),
        .wdata (cfg_wdata),
        .raddr (cnt),
        .rdata (step_pattern)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx    = state;
        cnt_nx      = cnt;
        len_nx      = len_q;
        loop_nx     = loop_q;
        buff_use_nx = '0;
        valid_nx    = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nx = RUN;
                    cnt_nx   = '0;
                    len_nx   = len_clamped;
                    loop_nx  = cfg_loop;
                end
            end
            RUN: begin
                if (abort) begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end else if (!stall) begin
                    buff_use_nx = step_pattern;
                    valid_nx    = 1'b1;
                    if (cnt != len_q) begin
                        cnt_nx = cnt + CNT_W'(1);
                    end else if (loop_q) begin
                        cnt_nx = '0;
                    end else begin
                        state_nx = DONE;
                    end
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // buff_use_valid qualifies buff_use for exactly one cycle per step; there
    // is no back-pressure, so a consumer must take the pattern when valid is high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt            <= '0;
            len_q          <= '0;
            loop_q         <= 1'b0;
            buff_use       <= '0;
            buff_use_valid <= 1'b0;
            cfg_err        <= 1'b0;
        end else begin
            cnt            <= cnt_nx;
            len_q          <= len_nx;
            loop_q         <= loop_nx;
            buff_use       <= buff_use_nx;
            buff_use_valid <= valid_nx;
            cfg_err        <= err_nx;
        end
    end

    assign busy      = (state == RUN);
    assign done      = (state == DONE);
    assign dbg_state = state;

endmodule

// File: tb/tb_custom_buff_use_sequencer.sv
// Randomised scoreboard bench for custom_buff_use_sequencer plus a small
// directed check on a 26-deep, 8-wide build.
module tb_custom_buff_use_sequencer;
    import custom_buff_pkg::*;

    localparam int NB = 4;
    localparam int D  = 32;
    localparam int CW = 5;
    localparam int NB2 = 8;
    localparam int D2  = 26;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          cfg_we, cfg_loop, start, stall, abort;
    logic [CW-1:0] cfg_addr, cfg_len, cnt;
    logic [NB-1:0] cfg_wdata, buff_use;
    logic          busy, done, buff_use_valid, cfg_err;
    state_e        dbg_state;

    logic           d2_we, d2_loop, d2_start, d2_stall, d2_abort;
    logic [4:0]     d2_addr, d2_len, d2_cnt;
    logic [NB2-1:0] d2_wdata, d2_buff_use;
    logic           d2_busy, d2_done, d2_valid, d2_err;
    state_e         d2_state;

    custom_buff_use_sequencer dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_wdata(cfg_wdata), .cfg_len(cfg_len), .cfg_loop(cfg_loop),
        .start(start), .stall(stall), .abort(abort), .busy(busy), .done(done),
        .cnt(cnt), .buff_use(buff_use), .buff_use_valid(buff_use_valid),
        .cfg_err(cfg_err), .dbg_state(dbg_state)
    );

    custom_buff_use_sequencer #(.NUM_BUFF(NB2), .SCHED_DEPTH(D2)) dut2 (
        .clk(clk), .rst(rst), .cfg_we(d2_we), .cfg_addr(d2_addr),
        .cfg_wdata(d2_wdata), .cfg_len(d2_len), .cfg_loop(d2_loop),
        .start(d2_start), .stall(d2_stall), .abort(d2_abort), .busy(d2_busy),
        .done(d2_done), .cnt(d2_cnt), .buff_use(d2_buff_use),
        .buff_use_valid(d2_valid), .cfg_err(d2_err), .dbg_state(d2_state)
    );

    // ---------------- checking ----------------
    int checks = 0;
    int errors = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // ---------------- reference model ----------------
    // Modes: 0 idle, 1 stepping, 2 the completion cycle.
    logic [NB-1:0] m_tbl [D];
    int            m_mode, m_step, m_len;
    bit            m_loop, m_err, m_pushed;
    logic [NB-1:0] exp_q [$];
    int            valid_seen = 0;
    int            done_seen  = 0;
    bit            mon_en     = 1'b0;

    task automatic model_clear();
        for (int i = 0; i < D; i++) m_tbl[i] = '0;
        m_mode = 0; m_step = 0; m_len = 0; m_loop = 1'b0;
        m_err = 1'b0; m_pushed = 1'b0;
        exp_q.delete();
    endtask

    // One clock of stimulus; the model predicts what the next edge does.
    task automatic cycle(input bit we, input int addr, input logic [NB-1:0] wd,
                         input bit st, input bit sl, input bit ab);
        cfg_we = we; cfg_addr = CW'(addr); cfg_wdata = wd;
        start = st; stall = sl; abort = ab;
        m_pushed = 1'b0;
        m_err = we && (m_mode == 1 || addr >= D);
        if (we && !m_err) m_tbl[addr] = wd;
        case (m_mode)
            0: if (st) begin
                m_mode = 1; m_step = 0; m_loop = cfg_loop;
                m_len  = (int'(cfg_len) > D - 1) ? D - 1 : int'(cfg_len);
            end
            1: if (ab) m_mode = 0;
               else if (!sl) begin
                exp_q.push_back(m_tbl[m_step]);
                m_pushed = 1'b1;
                if (m_step < m_len) m_step++;
                else if (m_loop)    m_step = 0;
                else                m_mode = 2;
            end
            default: m_mode = 0;
        endcase
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(1'b0, 0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic wr(input int a, input logic [NB-1:0] d);
        cycle(1'b1, a, d, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic go(input int len, input bit loop);
        cfg_len = CW'(len); cfg_loop = loop;
        cycle(1'b0, 0, '0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic run_to_step(input int k);
        int guard = 0;
        while (m_step != k && m_mode == 1 && guard < 64) begin
            idle(1);
            guard++;
        end
        chk("reach_step", 32'(m_step), 32'(k));
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (!rst && mon_en) begin
            chk("busy", 32'(busy), 32'(m_mode == 1));
            chk("done", 32'(done), 32'(m_mode == 2));
            chk("cfg_err", 32'(cfg_err), 32'(m_err));
            chk("valid", 32'(buff_use_valid), 32'(m_pushed));
            if (m_mode == 1) chk("cnt", 32'(cnt), 32'(m_step));
            if (done) done_seen++;
            if (buff_use_valid) begin
                valid_seen++;
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL buff_use actual=%0h expected=<none> at %0t", buff_use, $time);
                end else begin
                    chk("buff_use", 32'(buff_use), 32'(exp_q.pop_front()));
                end
            end else begin
                chk("buff_use_gap", 32'(buff_use), 32'(0));
            end
        end
    end

    // ---------------- second build: depth 26, width 8 ----------------
    logic [NB2-1:0] d2_exp [D2];

    task automatic d2_wr(input int a, input logic [NB2-1:0] d, input bit exp_err);
        d2_we = 1'b1; d2_addr = 5'(a); d2_wdata = d;
        @(posedge clk);
        @(negedge clk);
        d2_we = 1'b0;
        chk("d2_cfg_err", 32'(d2_err), 32'(exp_err));
        #1;
    endtask

    task automatic d2_test();
        int k, dn;
        d2_wr(27, 8'hFF, 1'b1);
        for (int i = 0; i < D2; i++) begin
            d2_exp[i] = 8'($urandom_range(0, 255));
            d2_wr(i, d2_exp[i], 1'b0);
        end
        d2_len = 5'd31; d2_loop = 1'b0; d2_start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        d2_start = 1'b0;
        k = 0; dn = 0;
        repeat (40) begin
            if (d2_valid) begin
                if (k < D2) chk("d2_buff_use", 32'(d2_buff_use), 32'(d2_exp[k]));
                k++;
            end
            if (d2_done) dn++;
            @(negedge clk);
        end
        chk("d2_valid_count", 32'(k), 32'(D2));
        chk("d2_done_count", 32'(dn), 32'(1));
        chk("d2_busy_after", 32'(d2_busy), 32'(0));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int d0, v0, e0;
        rst = 1'b1;
        cfg_we = 0; cfg_addr = '0; cfg_wdata = '0; cfg_len = '0; cfg_loop = 0;
        start = 0; stall = 0; abort = 0;
        d2_we = 0; d2_addr = '0; d2_wdata = '0; d2_len = '0; d2_loop = 0;
        d2_start = 0; d2_stall = 0; d2_abort = 0;
        model_clear();
        #3;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_cnt", 32'(cnt), 0);
        chk("rst_buff_use", 32'(buff_use), 0);
        chk("rst_valid", 32'(buff_use_valid), 0);
        chk("rst_cfg_err", 32'(cfg_err), 0);
        @(negedge clk);
        #1 rst = 1'b0;
        mon_en = 1'b1;

        // One-shot run over a sparse table: five zero steps then the pattern.
        wr(5, 4'b1000); wr(6, 4'b1100); wr(7, 4'b0110); wr(8, 4'b0010);
        d0 = done_seen;
        go(8, 1'b0);
        idle(12);
        chk("oneshot_done_count", 32'(done_seen - d0), 1);
        chk("oneshot_busy_after", 32'(busy), 0);

        // Write attempted while running is dropped and flagged.
        e0 = checks;
        go(4, 1'b0);
        cycle(1'b1, 2, 4'hF, 1'b0, 1'b0, 1'b0);
        idle(8);
        go(4, 1'b0);
        idle(8);

        // Looping run with abort.
        wr(0, 4'b0001); wr(1, 4'b0010); wr(2, 4'b0100);
        d0 = done_seen;
        go(2, 1'b1);
        idle(10);
        cycle(1'b0, 0, '0, 1'b0, 1'b0, 1'b1);
        chk("loop_no_done", 32'(done_seen - d0), 0);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_buff_use", 32'(buff_use), 0);
        chk("abort_valid", 32'(buff_use_valid), 0);
        chk("abort_cnt", 32'(cnt), 0);
        idle(2);

        // Three-cycle stall at step 3.
        for (int i = 0; i < 7; i++) wr(i, NB'($urandom_range(0, 15)));
        v0 = valid_seen;
        go(6, 1'b0);
        run_to_step(3);
        repeat (3) cycle(1'b0, 0, '0, 1'b0, 1'b1, 1'b0);
        idle(10);
        chk("stall_valid_count", 32'(valid_seen - v0), 7);

        // Write together with start, len 0 one-shot and looping, start in DONE.
        cycle(1'b1, 0, 4'hA, 1'b1, 1'b0, 1'b0);
        idle(5);
        go(0, 1'b0); idle(4);
        go(0, 1'b1); idle(5);
        cycle(1'b0, 0, '0, 1'b0, 1'b0, 1'b1);
        go(1, 1'b0); idle(2);
        cycle(1'b0, 0, '0, 1'b1, 1'b0, 1'b0);
        idle(4);
        go(31, 1'b0); idle(36);

        // Random traffic.
        repeat (400) begin
            cfg_len  = CW'($urandom_range(0, D - 1));
            cfg_loop = ($urandom_range(0, 2) == 0);
            cycle($urandom_range(0, 4) == 0, $urandom_range(0, D - 1),
                  NB'($urandom_range(0, 15)), $urandom_range(0, 5) == 0,
                  $urandom_range(0, 3) == 0, $urandom_range(0, 24) == 0);
        end
        cycle(1'b0, 0, '0, 1'b0, 1'b0, 1'b1);
        idle(3);
        chk("exp_q_drained", 32'(exp_q.size()), 0);

        // Asynchronous reset in the middle of a run.
        for (int i = 0; i < 16; i++) wr(i, NB'($urandom_range(1, 15)));
        go(15, 1'b0);
        run_to_step(10);
        d0 = done_seen;
        #2 rst = 1'b1;
        #1;
        mon_en = 1'b0;
        chk("arst_busy", 32'(busy), 0);
        chk("arst_done", 32'(done), 0);
        chk("arst_cnt", 32'(cnt), 0);
        chk("arst_buff_use", 32'(buff_use), 0);
        chk("arst_valid", 32'(buff_use_valid), 0);
        model_clear();
        @(negedge clk);
        #1 rst = 1'b0;
        mon_en = 1'b1;
        idle(2);
        chk("arst_no_done", 32'(done_seen - d0), 0);
        go(5, 1'b0);
        idle(8);
        chk("arst_rerun_done", 32'(done_seen - d0), 1);
        chk("exp_q_final", 32'(exp_q.size()), 0);

        d2_test();
        if (checks == e0) $display("FAIL no_checks_after_reject actual=%0d expected=more", checks);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout actual=%0t expected=finish", $time);
        $fatal(1, "timeout");
    end

endmodule
